// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default oversampling and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int UART_OVERSAMPLE = 16;

    // Even parity over up to eight data bits; narrower words are zero-extended by the caller.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RX line into the Clk domain and flags a 1->0 start edge.
module uart_rx_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    input  logic RX,
    output logic rx_s,
    output logic start_edge
);

    logic meta_r;
    logic sync_r;
    logic rx_d_r;

    // Two-flop synchroniser followed by a delayed copy for edge detection; idles high.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            rx_d_r <= 1'b1;
        end else begin
            meta_r <= RX;
            sync_r <= meta_r;
            rx_d_r <= sync_r;
        end
    end

    assign rx_s       = sync_r;
    assign start_edge = rx_d_r & ~sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with registered word and error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clear,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] OutData,
    output logic                 DataValid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Busy
);

    localparam int                OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   SAMP_PT  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   BEND_PT  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_ONE   = OS_W'(1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t            state_r;
    logic [OS_W-1:0]        os_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [DATA_BITS-1:0]   sr_r;
    logic                   par_r;
    logic [DATA_BITS-1:0]   out_data_r;
    logic                   dv_r;
    logic                   perr_r;
    logic                   ferr_r;
    logic                   busy_r;

    logic                   rx_s;
    logic                   start_edge_s;
    logic                   samp_s;
    logic                   bend_s;

    uart_rx_sync u_sync (
        .Clk        (Clk),
        .Rst        (Rst),
        .Clear      (Clear),
        .RX         (RX),
        .rx_s       (rx_s),
        .start_edge (start_edge_s)
    );

    assign samp_s = (os_cnt_r == SAMP_PT);
    assign bend_s = (os_cnt_r == BEND_PT);

    // Frame FSM with bit timing, shift register and registered result strobes.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            state_r    <= ST_IDLE;
            os_cnt_r   <= '0;
            bit_cnt_r  <= 3'd0;
            sr_r       <= '0;
            par_r      <= 1'b0;
            out_data_r <= '0;
            dv_r       <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            dv_r   <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            if (state_r != ST_IDLE) begin
                os_cnt_r <= os_cnt_r + OS_ONE;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        state_r  <= ST_START;
                        os_cnt_r <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                ST_START: begin
                    // A line that is high again mid start bit was only a glitch.
                    if (samp_s && rx_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (bend_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (samp_s) begin
                        sr_r <= {rx_s, sr_r[DATA_BITS-1:1]};
                    end
                    if (bend_s) begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp_s) begin
                        par_r <= rx_s;
                    end
                    if (bend_s) begin
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge from a fast sender is caught.
                    if (samp_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        out_data_r <= sr_r;
                        dv_r       <= 1'b1;
                        ferr_r     <= ~rx_s;
                        perr_r     <= (PARITY_EN != 0) && (par_r != even_parity(8'(sr_r)));
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign OutData   = out_data_r;
    assign DataValid = dv_r;
    assign ParityErr = perr_r;
    assign FrameErr  = ferr_r;
    assign Busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on RX, expected words queued, DataValid results popped and compared.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } rec_t;

    logic       Clk   = 1'b0;
    logic       Rst   = 1'b1;
    logic       Clear = 1'b0;
    logic       RX    = 1'b1;
    logic [7:0] OutData;
    logic       DataValid;
    logic       ParityErr;
    logic       FrameErr;
    logic       Busy;

    int   vectors     = 0;
    int   miscompares = 0;
    rec_t exp_q[$];
    rec_t got_q[$];

    always #5 Clk = ~Clk;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Clear     (Clear),
        .RX        (RX),
        .OutData   (OutData),
        .DataValid (DataValid),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    // Capture every DataValid cycle, so a stretched or repeated strobe shows up as an extra entry.
    always @(negedge Clk) begin
        if (DataValid) begin
            got_q.push_back(rec_t'{data: OutData, perr: ParityErr, ferr: FrameErr, busy: Busy});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [7:0] d, input logic p, input logic f);
        return rec_t'{data: d, perr: p, ferr: f, busy: 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int bit_ns);
        for (int i = 0; i < nbits; i++) begin
            RX = bits[i];
            #(bit_ns);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int bit_ns);
        send_bits({stop, par, d, 1'b0}, 11, bit_ns);
    endtask

    task automatic wait_results(input string tag, input int n, input int max_cycles);
        int c;
        c = 0;
        while (got_q.size() < n && c < max_cycles) begin
            @(negedge Clk);
            c++;
        end
        check({tag, "_timeout"}, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic pop_compare(input string tag);
        rec_t e;
        rec_t g;
        check({tag, "_avail"}, 32'(got_q.size() > 0 && exp_q.size() > 0), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, "_data"}, 32'(g.data), 32'(e.data));
            check({tag, "_perr"}, 32'(g.perr), 32'(e.perr));
            check({tag, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
            check({tag, "_busy"}, 32'(g.busy), 32'(e.busy));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_outdata"}, 32'(OutData), 32'h0);
        check({tag, "_dv"},      32'(DataValid), 32'd0);
        check({tag, "_perr"},    32'(ParityErr), 32'd0);
        check({tag, "_ferr"},    32'(FrameErr), 32'd0);
        check({tag, "_busy"},    32'(Busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check_outputs_zero("reset");

        // Clean frame 0xA5, correct even parity
        b = 8'hA5;
        exp_q.push_back(mk(b, 1'b0, 1'b0));
        send_frame(b, ^b, 1'b1, BIT_NS);
        #(BIT_NS);
        wait_results("a5", 1, 200);
        pop_compare("a5");
        check("a5_single", 32'(got_q.size()), 32'd0);

        // 0x01 with parity bit forced to 0
        b = 8'h01;
        exp_q.push_back(mk(b, 1'b1, 1'b0));
        send_frame(b, 1'b0, 1'b1, BIT_NS);
        #(BIT_NS);
        wait_results("par", 1, 200);
        pop_compare("par");

        // 0xFF with stop bit 0, then a 40-bit break
        b = 8'hFF;
        exp_q.push_back(mk(b, 1'b0, 1'b1));
        send_frame(b, ^b, 1'b0, BIT_NS);
        RX = 1'b0;
        #(40 * BIT_NS);
        wait_results("frm", 1, 200);
        pop_compare("frm");
        check("frm_break_no_dv", 32'(got_q.size()), 32'd0);
        check("frm_break_idle", 32'(Busy), 32'd0);
        RX = 1'b1;
        #(2 * BIT_NS);
        b = 8'h96;
        exp_q.push_back(mk(b, 1'b0, 1'b0));
        send_frame(b, ^b, 1'b1, BIT_NS);
        #(BIT_NS);
        wait_results("after_brk", 1, 200);
        pop_compare("after_brk");

        // 5-clock glitch in IDLE: short Busy burst, no word
        busy_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            RX = (i < 5) ? 1'b0 : 1'b1;
            @(negedge Clk);
            if (Busy) busy_cnt++;
        end
        check("glitch_busy_len", 32'(busy_cnt >= 7 && busy_cnt <= 9), 32'd1);
        check("glitch_no_dv", 32'(got_q.size()), 32'd0);

        // Back-to-back frames from a fast then a slow sender
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hC3, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b0, 1'b1, 155);
        send_frame(8'hC3, 1'b0, 1'b1, 165);
        RX = 1'b1;
        #(2 * BIT_NS);
        wait_results("b2b", 2, 200);
        pop_compare("b2b_0");
        pop_compare("b2b_1");
        check("b2b_count", 32'(got_q.size()), 32'd0);

        // Rst for one cycle in the middle of data bit 4
        send_bits(11'b0, 5, BIT_NS);
        RX = 1'b0;
        #(BIT_NS / 2);
        @(negedge Clk);
        check("rst_mid_busy", 32'(Busy), 32'd1);
        Rst = 1'b1;
        RX  = 1'b1;
        @(negedge Clk);
        check_outputs_zero("rst_mid");
        Rst = 1'b0;
        #(12 * BIT_NS);
        check("rst_mid_no_dv", 32'(got_q.size()), 32'd0);
        b = 8'h5A;
        exp_q.push_back(mk(b, 1'b0, 1'b0));
        send_frame(b, ^b, 1'b1, BIT_NS);
        #(BIT_NS);
        wait_results("after_rst", 1, 200);
        pop_compare("after_rst");

        // Clear mid frame behaves like Rst
        send_bits(11'b0, 3, BIT_NS);
        @(negedge Clk);
        check("clr_mid_busy", 32'(Busy), 32'd1);
        Clear = 1'b1;
        RX    = 1'b1;
        @(negedge Clk);
        check_outputs_zero("clr_mid");
        Clear = 1'b0;
        #(12 * BIT_NS);
        check("clr_mid_no_dv", 32'(got_q.size()), 32'd0);

        check("end_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
